// File: rtl/digital_clock_pkg.sv
// rtl/digital_clock_pkg.sv - BCD limits, time triple type and validity helpers for digital_clock
package digital_clock_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } time_t;

  // Both nibbles must be decimal digits; BCD then orders like binary, so a plain compare bounds it.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
    return (val[7:4] <= 4'h9) && (val[3:0] <= 4'h9) && (val <= max);
  endfunction

  function automatic logic time_valid(input time_t t);
    return bcd_valid(t.hh, HR_MAX) && bcd_valid(t.mm, MIN_MAX) && bcd_valid(t.ss, SEC_MAX);
  endfunction

endpackage

// File: rtl/digital_clock_if.sv
// rtl/digital_clock_if.sv - control/time bus between the clock core and its surroundings
interface digital_clock_if;

  logic       ena;
  logic [7:0] hh_in;
  logic [7:0] mm_in;
  logic [7:0] ss_in;
  logic       load;
  logic       put_alarm;
  logic       stop_alarm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       alarm;

  modport master (
    output ena, hh_in, mm_in, ss_in, load, put_alarm, stop_alarm,
    input  hh, mm, ss, alarm
  );

  modport slave (
    input  ena, hh_in, mm_in, ss_in, load, put_alarm, stop_alarm,
    output hh, mm, ss, alarm
  );

endinterface

// File: rtl/digital_clock_bcd_counter.sv
// rtl/digital_clock_bcd_counter.sv - two-digit BCD counter wrapping MAX to 00 with carry out
module bcd_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] r_q;
  logic [7:0] w_next;

  always_comb begin
    w_next = r_q;
    if (r_q == MAX) begin
      w_next = 8'h00;
    end else if (r_q[3:0] == 4'h9) begin
      w_next = {r_q[7:4] + 4'h1, 4'h0};
    end else begin
      w_next = {r_q[7:4], r_q[3:0] + 4'h1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 8'h00;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q     = r_q;
  assign carry = en && (r_q == MAX);

endmodule

// File: rtl/digital_clock.sv
// rtl/digital_clock.sv - 24-hour BCD time-of-day clock with parallel load and latched alarm
module digital_clock
  import digital_clock_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  digital_clock_if.slave bus
);

  time_t w_in;
  time_t w_now;
  logic  w_in_valid;
  logic  w_ld;
  logic  w_cnt_en;
  logic  w_ss_carry;
  logic  w_mm_carry;
  logic  w_match;

  time_t r_alarm_time;
  logic  r_armed;
  logic  r_alarm;

  assign w_in       = '{hh: bus.hh_in, mm: bus.mm_in, ss: bus.ss_in};
  assign w_in_valid = time_valid(w_in);
  assign w_ld       = bus.load && w_in_valid;
  // Any load request, valid or not, suppresses counting so a rejected load still holds time.
  assign w_cnt_en   = bus.ena && !bus.load;

  bcd_counter #(.MAX(SEC_MAX)) u_ss (
    .clk    (clk),
    .reset  (reset),
    .en     (w_cnt_en),
    .ld     (w_ld),
    .ld_val (bus.ss_in),
    .q      (bus.ss),
    .carry  (w_ss_carry)
  );

  bcd_counter #(.MAX(MIN_MAX)) u_mm (
    .clk    (clk),
    .reset  (reset),
    .en     (w_ss_carry),
    .ld     (w_ld),
    .ld_val (bus.mm_in),
    .q      (bus.mm),
    .carry  (w_mm_carry)
  );

  bcd_counter #(.MAX(HR_MAX)) u_hh (
    .clk    (clk),
    .reset  (reset),
    .en     (w_mm_carry),
    .ld     (w_ld),
    .ld_val (bus.hh_in),
    .q      (bus.hh),
    .carry  ()
  );

  assign w_now   = '{hh: bus.hh, mm: bus.mm, ss: bus.ss};
  assign w_match = r_armed && (w_now == r_alarm_time);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm_time <= '0;
      r_armed      <= 1'b0;
    end else if (bus.put_alarm && w_in_valid) begin
      r_alarm_time <= w_in;
      r_armed      <= 1'b1;
    end
  end

  // Acknowledge wins over a match in the same cycle; a persisting match re-fires afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm <= 1'b0;
    end else if (bus.stop_alarm) begin
      r_alarm <= 1'b0;
    end else if (w_match) begin
      r_alarm <= 1'b1;
    end
  end

  assign bus.alarm = r_alarm;

endmodule

// File: tb/tb_digital_clock.sv
// tb/tb_digital_clock.sv - directed self-checking bench for digital_clock
module tb_digital_clock;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  digital_clock_if bus ();

  digital_clock u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.hh_in = h;
    bus.mm_in = m;
    bus.ss_in = s;
  endtask

  function automatic logic [31:0] now();
    return {8'h00, bus.hh, bus.mm, bus.ss};
  endfunction

  task automatic load_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_in(h, m, s);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.ena        = 1'b0;
    bus.load       = 1'b0;
    bus.put_alarm  = 1'b0;
    bus.stop_alarm = 1'b0;
    set_in(8'h00, 8'h00, 8'h00);
    #1;

    step(2);
    check("reset_time", now(), 32'h000000);
    check("reset_alarm", {31'b0, bus.alarm}, 32'd0);

    reset   = 1'b0;
    bus.ena = 1'b1;
    step(100);
    check("count_100", now(), 32'h000140);

    set_in(8'h00, 8'h02, 8'h40);
    bus.load = 1'b1;
    step(1);
    check("load_first", now(), 32'h000240);
    step(9);
    check("load_held", now(), 32'h000240);
    bus.load = 1'b0;
    step(20);
    check("after_load", now(), 32'h000300);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_mid", now(), 32'h000000);

    bus.ena = 1'b0;
    load_time(8'h23, 8'h59, 8'h58);
    check("roll_load", now(), 32'h235958);
    bus.ena = 1'b1;
    step(1);
    check("roll_59", now(), 32'h235959);
    step(1);
    check("roll_wrap", now(), 32'h000000);
    bus.ena = 1'b0;
    load_time(8'h09, 8'h59, 8'h59);
    bus.ena = 1'b1;
    step(1);
    check("roll_09_10", now(), 32'h100000);
    bus.ena = 1'b0;
    load_time(8'h19, 8'h59, 8'h59);
    bus.ena = 1'b1;
    step(1);
    check("roll_19_20", now(), 32'h200000);
    check("no_alarm_unarmed", {31'b0, bus.alarm}, 32'd0);

    reset   = 1'b1;
    bus.ena = 1'b0;
    step(1);
    reset = 1'b0;
    set_in(8'h00, 8'h02, 8'h40);
    bus.put_alarm = 1'b1;
    bus.ena       = 1'b1;
    step(1);
    bus.put_alarm = 1'b0;
    step(159);
    check("alarm_match_time", now(), 32'h000240);
    check("alarm_not_yet", {31'b0, bus.alarm}, 32'd0);
    step(1);
    check("alarm_fires", {31'b0, bus.alarm}, 32'd1);
    step(139);
    check("alarm_t500", now(), 32'h000500);
    check("alarm_latched", {31'b0, bus.alarm}, 32'd1);
    bus.stop_alarm = 1'b1;
    step(1);
    bus.stop_alarm = 1'b0;
    check("alarm_stopped", {31'b0, bus.alarm}, 32'd0);
    step(5);
    check("alarm_stays_low", {31'b0, bus.alarm}, 32'd0);
    check("time_506", now(), 32'h000506);

    bus.ena = 1'b0;
    load_time(8'h24, 8'h00, 8'h00);
    check("bad_hh_load", now(), 32'h000506);
    bus.ena = 1'b1;
    load_time(8'h00, 8'h00, 8'h5A);
    check("bad_ss_load", now(), 32'h000506);
    bus.ena = 1'b0;

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_in(8'h00, 8'h60, 8'h00);
    bus.put_alarm = 1'b1;
    step(1);
    bus.put_alarm = 1'b0;
    step(1);
    check("bad_put_unarmed", {31'b0, bus.alarm}, 32'd0);
    set_in(8'h00, 8'h00, 8'h10);
    bus.put_alarm = 1'b1;
    step(1);
    set_in(8'h00, 8'h60, 8'h10);
    step(1);
    bus.put_alarm = 1'b0;
    bus.ena       = 1'b1;
    step(10);
    check("put_keep_time", now(), 32'h000010);
    check("put_keep_quiet", {31'b0, bus.alarm}, 32'd0);
    step(1);
    check("put_keep_fire", {31'b0, bus.alarm}, 32'd1);

    bus.ena = 1'b0;
    load_time(8'h00, 8'h00, 8'h10);
    check("sim_load", now(), 32'h000010);
    bus.stop_alarm = 1'b1;
    step(1);
    check("sim_stop_wins", {31'b0, bus.alarm}, 32'd0);
    step(1);
    check("sim_stop_hold", {31'b0, bus.alarm}, 32'd0);
    bus.stop_alarm = 1'b0;
    step(1);
    check("sim_refire", {31'b0, bus.alarm}, 32'd1);

    set_in(8'h12, 8'h34, 8'h56);
    bus.load = 1'b1;
    reset    = 1'b1;
    step(1);
    bus.load = 1'b0;
    reset    = 1'b0;
    check("reset_over_load", now(), 32'h000000);
    check("reset_clr_alarm", {31'b0, bus.alarm}, 32'd0);
    step(2);
    check("reset_clr_armed", {31'b0, bus.alarm}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
